// File: rtl/ctrl_seq4_pkg.sv
// Shared definitions for the 4-bit fetch/decode/execute sequencer:
// state encodings, opcodes and ALU operation codes.
package ctrl_seq4_pkg;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StHalt   = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOr  = 2'b11
    } alu_op_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLda  = 4'h1;
    localparam logic [3:0] OpLdb  = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpSub  = 4'h4;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpOr   = 4'h6;
    localparam logic [3:0] OpMovb = 4'h7;
    localparam logic [3:0] OpOut  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpJz   = 4'hA;
    localparam logic [3:0] OpJc   = 4'hB;
    localparam logic [3:0] OpHlt  = 4'hF;

    // Only the ALU-result opcodes update the zero/carry flags.
    function automatic logic sets_flags(input logic [3:0] op);
        return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);
    endfunction

endpackage

// File: rtl/ctrl_seq4_pc_cnt.sv
// Program counter: synchronous reset, parallel load (priority) or increment.
module ctrl_seq4_pc_cnt #(
    parameter int unsigned PC_W = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;

    // Counter register; wraps naturally modulo 2**PC_W.
    always_ff @(posedge clk) begin
        if (res) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= load_val;
        end else if (inc) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ctrl_seq4.sv
// Fetch/decode/execute sequencer for the 4-bit datapath. Three clocks per
// instruction; all enables and selects decode from registered state and ir.
module ctrl_seq4
    import ctrl_seq4_pkg::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              run,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic              en_a,
    output logic              en_b,
    output logic              en_out,
    output logic              a_sel,
    output logic              b_sel,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] imm,
    output logic              halted
);

    ctrl_state_e     state_q, state_d;
    logic [7:0]      ir_q, ir_d;
    logic            z_flag_q, z_flag_d;
    logic            c_flag_q, c_flag_d;
    logic            pc_inc, pc_load;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode;

    assign opcode = ir_q[7:4];

    ctrl_seq4_pc_cnt #(
        .PC_W(PC_W)
    ) u_pc_cnt (
        .clk     (clk),
        .res     (res),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_val(PC_W'(ir_q[3:0])),
        .pc      (pc)
    );

    // State, instruction and flag registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= StFetch;
            ir_q     <= '0;
            z_flag_q <= 1'b0;
            c_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            z_flag_q <= z_flag_d;
            c_flag_q <= c_flag_d;
        end
    end

    // Next-state, PC control and EXEC-cycle output decode.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        z_flag_d = z_flag_q;
        c_flag_d = c_flag_q;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_out   = 1'b0;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        alu_op   = AluAdd;

        unique case (state_q)
            StFetch: begin
                if (run) begin
                    ir_d    = rom_data;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpLda:  begin en_a = 1'b1; a_sel = 1'b1; end
                    OpLdb:  begin en_b = 1'b1; end
                    OpAdd:  begin en_a = 1'b1; alu_op = AluAdd; end
                    OpSub:  begin en_a = 1'b1; alu_op = AluSub; end
                    OpAnd:  begin en_a = 1'b1; alu_op = AluAnd; end
                    OpOr:   begin en_a = 1'b1; alu_op = AluOr; end
                    OpMovb: begin en_b = 1'b1; b_sel = 1'b1; end
                    OpOut:  begin en_out = 1'b1; end
                    OpJmp:  begin pc_load = 1'b1; end
                    OpJz:   begin pc_load = z_flag_q; end
                    OpJc:   begin pc_load = c_flag_q; end
                    OpHlt:  begin state_d = StHalt; end
                    default: ;
                endcase
                if (sets_flags(opcode)) begin
                    z_flag_d = alu_z;
                    c_flag_d = alu_c;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign rom_addr = pc;
    assign imm      = DATA_W'(ir_q[3:0]);
    assign halted   = (state_q == StHalt);

endmodule
